// File: rtl/seg7_pkg.sv
// Shared definitions for the binary-to-BCD display path: FSM states,
// double-dabble adjust constants and the digit-count sanity helper.
package seg7_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // True when 'digits' decimal digits can hold the largest bin_w-bit value.
  function automatic bit digits_ok(int unsigned bin_w, int unsigned digits);
    longint unsigned maxv;
    int unsigned     need;
    maxv = (64'd1 << bin_w) - 64'd1;
    need = 0;
    while (maxv != 64'd0) begin
      maxv = maxv / 64'd10;
      need++;
    end
    if (need == 0) need = 1;
    return digits >= need;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// (4-bit wrap, no carry out).
module bcd_digit_adj
  import seg7_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= BCD_ADJ_THRESH) ? d_i + BCD_ADJ_ADD : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a held display result.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [DIGITS-1:0] EN_RST = DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] EN_RST = '1;
`endif

  if (!digits_ok(BIN_W, DIGITS)) begin : g_size_chk
    $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  en_q, en_d;
  logic               valid_q, valid_d;

  logic [BCD_W-1:0]       scratch_adj;
  logic [BCD_W+BIN_W-1:0] cat_nxt;
  logic [BCD_W-1:0]       scratch_nxt;
  logic [BIN_W-1:0]       shift_nxt;
  logic [DIGITS-1:0]      final_en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (scratch_q[4*g +: 4]),
      .d_o (scratch_adj[4*g +: 4])
    );
  end

  assign cat_nxt     = {scratch_adj, shift_q} << 1;
  assign scratch_nxt = cat_nxt[BCD_W+BIN_W-1:BIN_W];
  assign shift_nxt   = cat_nxt[BIN_W-1:0];

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; once a nonzero digit is seen, all lower digits show.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    final_en = '0;
    final_en[0] = 1'b1;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      seen = seen | (scratch_nxt[4*(DIGITS-1-i) +: 4] != 4'd0);
      final_en[DIGITS-1-i] = seen;
    end
  end
`else
  assign final_en = '1;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    en_d      = en_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_nxt;
        scratch_d = scratch_nxt;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d   = scratch_nxt;
          en_d    = final_en;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      en_q      <= EN_RST;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      valid_q   <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign bcd_out   = bcd_q;
  assign digit_en  = en_q;

endmodule
